// File: rtl/sd_pkg.sv
// Shared definitions for the SD block loader: card register map, copy geometry, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_pkg;

    localparam logic [15:0] SD_REG_ADDR      = 16'h1000;
    localparam logic [15:0] SD_REG_RD        = 16'h1004;
    localparam logic [15:0] SD_REG_READY     = 16'h2010;
    localparam int          SD_READY_BIT     = 24;
    localparam int          SD_WORDS_PER_BLK = 128;
    localparam logic [31:0] SD_RD_CMD        = 32'h0100_0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL0,
        ST_SETADDR,
        ST_CMDRD,
        ST_SETTLE,
        ST_POLL1,
        ST_COPY,
        ST_NEXT,
        ST_DONE
    } sd_state_e;

    // The card's control registers are big-endian relative to the bus.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/sd_block_loader_poll_timer.sv
// Poll timeout counter: counts enabled cycles from clear, saturates and flags at LIMIT.
// Latency: expired_o is registered-count based, visible the cycle the count reaches LIMIT.
// Backpressure: none.
module sd_poll_timer #(
    parameter logic [23:0] LIMIT = 24'hffffff
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [23:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_block_loader.sv
// Copies nblk 512-byte sectors from the SPI SD card block into memory; SD_LOADER_CSUM_EN adds a data checksum.
// Latency: per block, card ready wait + 2 command cycles + SETTLE_CYC + 128 words at >= 2 cycles each.
// Backpressure: mem_we holds address/data stable until mem_ready; card readiness is polled with timeout.
module sd_block_loader
    import sd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC  = 24'hffffff,
    parameter int          SECTOR_BYTES = 512,
    parameter int          SETTLE_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] sd_base,
    input  logic [31:0] mem_base,
    input  logic [15:0] nblk,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] sd_a,
    output logic [31:0] sd_d,
    output logic        sd_we,
    input  logic [31:0] sd_spo,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    input  logic        mem_ready
`ifdef SD_LOADER_CSUM_EN
    ,
    output logic [31:0] csum
`endif
);

    sd_state_e   state_q, state_d;
    logic [31:0] cur_sd_q, cur_sd_d;
    logic [31:0] cur_mem_q, cur_mem_d;
    logic [15:0] rem_q, rem_d;
    logic [6:0]  w_q, w_d;
    logic [7:0]  settle_q, settle_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_d_q, mem_d_d;
    logic        poll_en;
    logic        poll_expired;
    logic        card_ready;
    logic        mem_accept;

    assign card_ready = sd_spo[SD_READY_BIT];
    assign poll_en    = (state_q == ST_POLL0) || (state_q == ST_POLL1);
    assign mem_accept = mem_we_q && mem_ready;

    // Counter is held clear outside the poll states, so each poll entry starts fresh.
    sd_poll_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_poll_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (poll_en),
        .clr_i    (!poll_en),
        .expired_o(poll_expired)
    );

    always_comb begin
        state_d   = state_q;
        cur_sd_d  = cur_sd_q;
        cur_mem_d = cur_mem_q;
        rem_d     = rem_q;
        w_d       = w_q;
        settle_d  = settle_q;
        err_d     = err_q;
        mem_we_d  = mem_we_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        sd_a      = '0;
        sd_d      = '0;
        sd_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_sd_d  = sd_base;
                    cur_mem_d = mem_base;
                    rem_d     = nblk;
                    err_d     = 1'b0;
                    state_d   = (nblk == 16'd0) ? ST_DONE : ST_POLL0;
                end
            end
            ST_POLL0, ST_POLL1: begin
                sd_a = SD_REG_READY;
                if (card_ready) begin
                    if (state_q == ST_POLL0) begin
                        state_d = ST_SETADDR;
                    end else begin
                        state_d  = ST_COPY;
                        w_d      = '0;
                        mem_we_d = 1'b0;
                    end
                end else if (poll_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_SETADDR: begin
                sd_a    = SD_REG_ADDR;
                sd_d    = bswap32(cur_sd_q);
                sd_we   = 1'b1;
                state_d = ST_CMDRD;
            end
            ST_CMDRD: begin
                sd_a     = SD_REG_RD;
                sd_d     = SD_RD_CMD;
                sd_we    = 1'b1;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == 8'(SETTLE_CYC - 1)) begin
                    state_d = ST_POLL1;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_COPY: begin
                sd_a = {7'd0, w_q, 2'b00};
                // Capture the cache word when the request rises; hold it until accepted.
                if (!mem_we_q) begin
                    mem_we_d = 1'b1;
                    mem_d_d  = sd_spo;
                    mem_a_d  = cur_mem_q + {23'd0, w_q, 2'b00};
                end else if (mem_ready) begin
                    mem_we_d = 1'b0;
                    if (w_q == 7'(SD_WORDS_PER_BLK - 1)) begin
                        state_d = ST_NEXT;
                    end else begin
                        w_d = w_q + 7'd1;
                    end
                end
            end
            ST_NEXT: begin
                cur_sd_d  = cur_sd_q + 32'(SECTOR_BYTES);
                cur_mem_d = cur_mem_q + 32'(SECTOR_BYTES);
                rem_d     = rem_q - 16'd1;
                state_d   = (rem_q == 16'd1) ? ST_DONE : ST_POLL0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_sd_q  <= '0;
            cur_mem_q <= '0;
            rem_q     <= '0;
            w_q       <= '0;
            settle_q  <= '0;
            err_q     <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_sd_q  <= cur_sd_d;
            cur_mem_q <= cur_mem_d;
            rem_q     <= rem_d;
            w_q       <= w_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
        end
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_d  = mem_d_q;

`ifdef SD_LOADER_CSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && start) begin
            csum_d = '0;
        end else if (mem_accept) begin
            csum_d = csum_q + mem_d_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = mem_accept;
`endif

endmodule
